// File: rtl/cic_dec_ctrl.sv
// CIC decimator sequencer: sample handshake, integrator enable/clear, decimation strobe, output handshake.
// Optional build macro CIC_CTRL_DROP_EN: never backpressure, drop colliding outputs and count them.
module cic_dec_ctrl #(
  parameter int unsigned RATE_W     = 8,
  parameter int unsigned COMB_LAT   = 2,
  parameter int unsigned CLR_CYCLES = 2
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic [RATE_W-1:0] rate_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  output logic              integ_en_o,
  output logic              integ_clr_o,
  output logic              comb_en_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic              busy_o,
  output logic [RATE_W-1:0] dec_cnt_o
`ifdef CIC_CTRL_DROP_EN
  ,
  output logic [15:0]       drop_cnt_o
`endif
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CLEAR = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_FLUSH = 2'd3;

  localparam int unsigned     CLR_W    = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
  localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLR_CYCLES - 1);

  logic [1:0]          state_q, state_d;
  logic [RATE_W-1:0]   rate_q, rate_d;
  logic [RATE_W-1:0]   dec_cnt_q, dec_cnt_d;
  logic [CLR_W-1:0]    clr_cnt_q, clr_cnt_d;
  logic                comb_en_q, comb_en_d;
  logic [COMB_LAT-1:0] pipe_q, pipe_d;
  logic                out_valid_q, out_valid_d;
  logic                pipe_busy, at_wrap, pending, accept;
`ifdef CIC_CTRL_DROP_EN
  logic [15:0]         drop_cnt_q, drop_cnt_d;
`endif

  // The slot ending at out_valid counts as busy, giving one output per COMB_LAT+2 cycles at R=1.
  always_comb begin
    pipe_busy = |pipe_q;
    at_wrap   = (dec_cnt_q == rate_q - 1'b1);
    pending   = pipe_busy | comb_en_q | (out_valid_q & ~out_ready_i);
`ifdef CIC_CTRL_DROP_EN
    in_ready_o = (state_q == ST_RUN);
`else
    in_ready_o = (state_q == ST_RUN) & ~(at_wrap & pending);
`endif
    accept     = in_valid_i & in_ready_o;
  end

  always_comb begin
    state_d   = state_q;
    rate_d    = rate_q;
    dec_cnt_d = dec_cnt_q;
    clr_cnt_d = clr_cnt_q;
    comb_en_d = 1'b0;
`ifdef CIC_CTRL_DROP_EN
    drop_cnt_d = drop_cnt_q;
`endif
    pipe_d    = '0;
    pipe_d[0] = comb_en_q;
    for (int unsigned i = 1; i < COMB_LAT; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
    out_valid_d = pipe_d[COMB_LAT-1] | (out_valid_q & ~out_ready_i);

    case (state_q)
      ST_IDLE: begin
        dec_cnt_d = '0;
        if (start_i) begin
          rate_d    = (rate_i <= RATE_W'(1)) ? RATE_W'(1) : rate_i;
          clr_cnt_d = '0;
          state_d   = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        dec_cnt_d = '0;
`ifdef CIC_CTRL_DROP_EN
        drop_cnt_d = '0;
`endif
        if (clr_cnt_q == CLR_LAST) begin
          state_d = ST_RUN;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (accept) begin
          if (at_wrap) begin
            dec_cnt_d = '0;
`ifdef CIC_CTRL_DROP_EN
            if (pending) begin
              if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + 16'd1;
            end else begin
              comb_en_d = 1'b1;
            end
`else
            comb_en_d = 1'b1;
`endif
          end else begin
            dec_cnt_d = dec_cnt_q + 1'b1;
          end
        end
        if (stop_i) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (!pipe_busy && !comb_en_q && !out_valid_q) begin
          state_d   = ST_IDLE;
          dec_cnt_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= ST_IDLE;
      rate_q      <= RATE_W'(1);
      dec_cnt_q   <= '0;
      clr_cnt_q   <= '0;
      comb_en_q   <= 1'b0;
      pipe_q      <= '0;
      out_valid_q <= 1'b0;
`ifdef CIC_CTRL_DROP_EN
      drop_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      rate_q      <= rate_d;
      dec_cnt_q   <= dec_cnt_d;
      clr_cnt_q   <= clr_cnt_d;
      comb_en_q   <= comb_en_d;
      pipe_q      <= pipe_d;
      out_valid_q <= out_valid_d;
`ifdef CIC_CTRL_DROP_EN
      drop_cnt_q  <= drop_cnt_d;
`endif
    end
  end

  assign integ_en_o  = accept;
  assign integ_clr_o = (state_q == ST_CLEAR);
  assign comb_en_o   = comb_en_q;
  assign out_valid_o = out_valid_q;
  assign busy_o      = (state_q != ST_IDLE);
  assign dec_cnt_o   = dec_cnt_q;
`ifdef CIC_CTRL_DROP_EN
  assign drop_cnt_o  = drop_cnt_q;
`endif

endmodule

// File: tb/tb_cic_dec_ctrl.sv
// Bench for cic_dec_ctrl: vector table for the first run, scoreboard of expected comb/output
// cycles driven from accepted samples, and hand sequences for backpressure, flush and reset.
module tb_cic_dec_ctrl;
  localparam int unsigned RATE_W     = 8;
  localparam int unsigned COMB_LAT   = 2;
  localparam int unsigned CLR_CYCLES = 2;

  logic              clk_i = 1'b0;
  logic              rstn_i = 1'b0;
  logic              start_i = 1'b0, stop_i = 1'b0;
  logic [RATE_W-1:0] rate_i = '0;
  logic              in_valid_i = 1'b0, out_ready_i = 1'b0;
  logic              in_ready_o, integ_en_o, integ_clr_o, comb_en_o, out_valid_o, busy_o;
  logic [RATE_W-1:0] dec_cnt_o;
`ifdef CIC_CTRL_DROP_EN
  logic [15:0]       drop_cnt_o;
`endif

  cic_dec_ctrl #(.RATE_W(RATE_W), .COMB_LAT(COMB_LAT), .CLR_CYCLES(CLR_CYCLES)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .start_i(start_i), .stop_i(stop_i), .rate_i(rate_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .integ_en_o(integ_en_o),
    .integ_clr_o(integ_clr_o), .comb_en_o(comb_en_o), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .busy_o(busy_o), .dec_cnt_o(dec_cnt_o)
`ifdef CIC_CTRL_DROP_EN
    , .drop_cnt_o(drop_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: expected cycle of each comb strobe and each out_valid rise.
  int   comb_q[$];
  int   ov_q[$];
  int   m_rate  = 1;
  int   m_phase = 0;
  bit   sb_en   = 1'b1;
  logic prev_ov = 1'b0;

  always @(negedge clk_i) begin
    if (!rstn_i) begin
      prev_ov = 1'b0;
    end else if (sb_en) begin
      if (comb_en_o) begin
        if (comb_q.size() == 0) check("comb_unexpected", 1, 0);
        else check("comb_cycle", cyc, comb_q.pop_front());
      end
      if (out_valid_o && !prev_ov) begin
        if (ov_q.size() == 0) check("ov_unexpected", 1, 0);
        else check("ov_cycle", cyc, ov_q.pop_front());
      end
      prev_ov = out_valid_o;
      if (in_valid_i && in_ready_o) begin
        check("dec_phase", dec_cnt_o, m_phase);
        check("integ_en", integ_en_o, 1);
        m_phase++;
        if (m_phase == m_rate) begin
          m_phase = 0;
          comb_q.push_back(cyc + 1);
          ov_q.push_back(cyc + 1 + COMB_LAT);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic start_run(input int r);
    m_rate     = (r < 2) ? 1 : r;
    m_phase    = 0;
    rate_i     = RATE_W'(r);
    start_i    = 1'b1;
    tick();
    start_i    = 1'b0;
    rate_i     = '1;
    tick();
    tick();
  endtask

  task automatic go_idle();
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    stop_i      = 1'b1;
    tick();
    stop_i = 1'b0;
    for (int k = 0; k < 20 && busy_o; k++) tick();
    check("idle_reached", busy_o, 0);
    check("sb_drained", comb_q.size() + ov_q.size(), 0);
  endtask

  typedef struct {
    logic              start, stop;
    logic [RATE_W-1:0] rate;
    logic              iv, ordy;
    logic              e_rdy, e_en, e_clr, e_comb, e_ov, e_busy;
    logic [RATE_W-1:0] e_dec;
  } vec_t;

  vec_t vecs[15];
  int   acc;
  int   combs;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // start, stop, rate, iv, or | rdy, en, clr, comb, ov, busy, dec
    vecs[0]  = '{1, 1, 4, 0, 1,  0, 0, 0, 0, 0, 0, 0};
    vecs[1]  = '{0, 0, 9, 0, 1,  0, 0, 1, 0, 0, 1, 0};
    vecs[2]  = '{0, 0, 9, 0, 1,  0, 0, 1, 0, 0, 1, 0};
    vecs[3]  = '{0, 0, 9, 1, 1,  1, 1, 0, 0, 0, 1, 0};
    vecs[4]  = '{0, 0, 9, 1, 1,  1, 1, 0, 0, 0, 1, 1};
    vecs[5]  = '{0, 0, 9, 1, 1,  1, 1, 0, 0, 0, 1, 2};
    vecs[6]  = '{0, 0, 9, 1, 1,  1, 1, 0, 0, 0, 1, 3};
    vecs[7]  = '{0, 0, 9, 1, 1,  1, 1, 0, 1, 0, 1, 0};
    vecs[8]  = '{0, 0, 9, 1, 1,  1, 1, 0, 0, 0, 1, 1};
    vecs[9]  = '{0, 0, 9, 1, 1,  1, 1, 0, 0, 1, 1, 2};
    vecs[10] = '{0, 0, 9, 1, 1,  1, 1, 0, 0, 0, 1, 3};
    vecs[11] = '{0, 0, 9, 0, 1,  1, 0, 0, 1, 0, 1, 0};
    vecs[12] = '{0, 0, 9, 0, 1,  1, 0, 0, 0, 0, 1, 0};
    vecs[13] = '{0, 0, 9, 0, 1,  1, 0, 0, 0, 1, 1, 0};
    vecs[14] = '{0, 0, 9, 0, 1,  1, 0, 0, 0, 0, 1, 0};

    repeat (2) @(posedge clk_i);
    #1;
    check("reset_outputs", {in_ready_o, integ_en_o, integ_clr_o, comb_en_o, out_valid_o, busy_o, dec_cnt_o}, 0);
    rstn_i = 1'b1;
    tick();
    check("idle_outputs", {in_ready_o, integ_clr_o, comb_en_o, out_valid_o, busy_o, dec_cnt_o}, 0);

    // Rate 4, eight back-to-back samples; start+stop together, rate_i wiggled after start
    m_rate  = 4;
    m_phase = 0;
    for (int i = 0; i < 15; i++) begin
      start_i = vecs[i].start; stop_i = vecs[i].stop; rate_i = vecs[i].rate;
      in_valid_i = vecs[i].iv; out_ready_i = vecs[i].ordy;
      @(negedge clk_i);
      check($sformatf("vec%0d", i),
            {in_ready_o, integ_en_o, integ_clr_o, comb_en_o, out_valid_o, busy_o, dec_cnt_o},
            {vecs[i].e_rdy, vecs[i].e_en, vecs[i].e_clr, vecs[i].e_comb, vecs[i].e_ov,
             vecs[i].e_busy, vecs[i].e_dec});
      tick();
    end
    start_i = 1'b0; stop_i = 1'b0;
    go_idle();

`ifndef CIC_CTRL_DROP_EN
    // rate_i 0 and 1 both behave as R=1: one accept every COMB_LAT+2 cycles
    for (int r = 0; r < 2; r++) begin
      start_run(r);
      in_valid_i = 1'b1; out_ready_i = 1'b1; acc = 0;
      for (int k = 0; k < 16; k++) begin
        @(negedge clk_i);
        check("r1_ready", in_ready_o, (k % 4) == 0);
        if (in_ready_o) acc++;
        tick();
      end
      check("r1_accepts", acc, 4);
      go_idle();
    end

    // Rate 3 with stalled sink: second wrap is held off at dec_cnt 2
    start_run(3);
    in_valid_i = 1'b1; out_ready_i = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk_i);
      check("bp_ready", in_ready_o, k < 5);
      tick();
    end
    @(negedge clk_i);
    check("bp_hold", {in_ready_o, out_valid_o, dec_cnt_o}, {1'b0, 1'b1, 8'd2});
    tick();
    in_valid_i = 1'b0; out_ready_i = 1'b1;
    @(negedge clk_i);
    check("bp_handshake", out_valid_o, 1);
    tick();
    @(negedge clk_i);
    check("bp_release", {in_ready_o, out_valid_o}, 2'b10);
    tick();
    in_valid_i = 1'b1;
    @(negedge clk_i);
    check("bp_wrap_accept", in_ready_o, 1);
    tick();
    go_idle();

    // Stop at dec_cnt 2 with an output pending
    start_run(4);
    in_valid_i = 1'b1; out_ready_i = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk_i);
      check("fl_ready", in_ready_o, 1);
      tick();
    end
    in_valid_i = 1'b0; stop_i = 1'b1;
    @(negedge clk_i);
    check("fl_stop_cycle", {out_valid_o, dec_cnt_o}, {1'b1, 8'd2});
    tick();
    stop_i = 1'b0; in_valid_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      check("fl_hold", {busy_o, in_ready_o, integ_en_o, out_valid_o}, 4'b1001);
      tick();
    end
    in_valid_i = 1'b0; out_ready_i = 1'b1;
    for (int k = 0; k < 10 && busy_o; k++) tick();
    check("fl_idle", {busy_o, out_valid_o, dec_cnt_o}, 0);
    check("fl_drained", comb_q.size() + ov_q.size(), 0);
`endif

    // Asynchronous reset while an output is pending
    start_run(1);
    in_valid_i = 1'b1; out_ready_i = 1'b0;
    tick();
    in_valid_i = 1'b0;
    for (int k = 0; k < 10 && !out_valid_o; k++) tick();
    check("ar_pending", out_valid_o, 1);
    @(negedge clk_i);
    #2;
    rstn_i = 1'b0;
    #1;
    check("async_reset", {in_ready_o, integ_en_o, integ_clr_o, comb_en_o, out_valid_o, busy_o, dec_cnt_o}, 0);
    comb_q.delete();
    ov_q.delete();
    tick();
    rstn_i = 1'b1;
    tick();
    start_run(2);
    out_ready_i = 1'b1;
    for (int s = 0; s < 4; s++) begin
      in_valid_i = 1'b1;
      @(negedge clk_i);
      check("ar_restart_ready", in_ready_o, 1);
      tick();
      in_valid_i = 1'b0;
      repeat (6) tick();
    end
    go_idle();

`ifdef CIC_CTRL_DROP_EN
    // Rate 2, stalled sink: ten samples, four outputs dropped
    rstn_i = 1'b0;
    tick();
    rstn_i = 1'b1;
    sb_en = 1'b0;
    start_run(2);
    in_valid_i = 1'b1; out_ready_i = 1'b0; combs = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk_i);
      check("drop_ready", in_ready_o, 1);
      if (comb_en_o) combs++;
      tick();
    end
    in_valid_i = 1'b0;
    tick();
    tick();
    check("drop_cnt", drop_cnt_o, 4);
    check("drop_combs", combs, 1);
    comb_q.delete();
    ov_q.delete();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
